// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg
//   Shared video definitions for the 640x480@60 raster generator.
//   Holds the default horizontal/vertical timing constants, the pixel
//   clock divide ratio, the 10-bit coordinate type used for the Pixel and
//   Line counters, and the state encoding of the run/stop sequencer.
package vga_timing_gen_pkg;

  // Horizontal timing in pixel clocks.
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  // Vertical timing in lines.
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // 100 MHz system clock cycles per 25 MHz pixel.
  localparam int CLK_DIV_DEF  = 4;

  // Raster coordinates are 10 bits wide (covers 0..799 and 0..524).
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Run/stop sequencer states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/vga_timing_gen_pix_div.sv
// vga_pix_div
//   Pixel-enable strobe generator. Counts clk100 cycles 0..CLK_DIV-1 while
//   enabled and raises pix_en (registered) for the one cycle in which the
//   count sits at CLK_DIV-1. A clear forces the count back to 0 so the
//   first strobe after a start lands exactly CLK_DIV-1 cycles later.
//
//   Ports:
//     clk100  in   system clock
//     rst_n   in   asynchronous active-low reset
//     enable  in   count while high; count parks at 0 while low
//     clear   in   restart the count from 0 (wins over enable)
//     pix_en  out  one-cycle strobe once every CLK_DIV cycles
module vga_pix_div
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk100,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic pix_en
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_next;

  // Next divider value: wrap at CLK_DIV-1, hold at zero when stopped or
  // cleared so a restart always begins a fresh pixel period.
  always_comb begin
    div_next = '0;
    if (!clear && enable) begin
      div_next = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  // The strobe is registered from the next count so it is high exactly in
  // the cycle where the divider register holds CLK_DIV-1.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      pix_en <= 1'b0;
    end else begin
      div_q  <= div_next;
      pix_en <= !clear && enable && (div_next == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   640x480@60 raster timing generator running from the 100 MHz clock.
//   Produces the Pixel/Line counters, hsync/vsync, data enable and a
//   frame_start pulse, all registered together so every output describes
//   the coordinate presented in the same cycle. Counters advance only on
//   the 25 MHz pix_en strobe. A level run request starts the raster at
//   (0,0); dropping it lets the current frame finish before parking.
//
//   Ports:
//     clk100       in   system clock, 100 MHz
//     rst_n        in   asynchronous active-low reset
//     run          in   level request to produce video
//     pix_en       out  pixel strobe, once every CLK_DIV cycles while running
//     Pixel        out  horizontal counter 0..H_TOTAL-1
//     Line         out  vertical counter 0..V_TOTAL-1
//     hsync        out  horizontal sync, active level SYNC_POL
//     vsync        out  vertical sync, active level SYNC_POL
//     de           out  high inside the active H_ACTIVE x V_ACTIVE area
//     frame_start  out  one-cycle pulse in the first cycle of (0,0)
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk100,
  input  logic               rst_n,
  input  logic               run,
  output logic               pix_en,
  output logic [COORD_W-1:0] Pixel,
  output logic [COORD_W-1:0] Line,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               frame_start
);

  localparam coord_t H_ACT        = coord_t'(H_ACTIVE);
  localparam coord_t H_SYNC_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t H_LAST       = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_ACT        = coord_t'(V_ACTIVE);
  localparam coord_t V_SYNC_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam coord_t V_LAST       = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  state_t state;
  state_t state_next;
  coord_t pixel_next;
  coord_t line_next;
  logic   fs_next;
  logic   de_next;
  logic   hsync_next;
  logic   vsync_next;
  logic   div_clear;
  logic   div_enable;
  logic   at_end;
  logic   visible;

  assign div_enable = (state != IDLE);

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk100 (clk100),
    .rst_n  (rst_n),
    .enable (div_enable),
    .clear  (div_clear),
    .pix_en (pix_en)
  );

  // Sequencer and raster next-state. The counters step on pix_en, which is
  // high in the last cycle of each pixel period, so the new coordinate and
  // the syncs/de decoded from it all land on the same clock edge. Stopping
  // is only honoured on the final pixel of a frame, so the parked position
  // is always (0,0) and a frame is never cut short.
  always_comb begin
    state_next = state;
    pixel_next = Pixel;
    line_next  = Line;
    fs_next    = 1'b0;
    div_clear  = 1'b0;
    at_end     = (Pixel == H_LAST) && (Line == V_LAST);

    case (state)
      IDLE: begin
        pixel_next = '0;
        line_next  = '0;
        if (run) begin
          state_next = RUN;
          div_clear  = 1'b1;
          fs_next    = 1'b1;
        end
      end
      RUN: begin
        if (!run) state_next = STOPPING;
      end
      STOPPING: begin
        if (run) state_next = RUN;
        else if (pix_en && at_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if ((state != IDLE) && pix_en) begin
      if (Pixel == H_LAST) begin
        pixel_next = '0;
        line_next  = (Line == V_LAST) ? '0 : Line + coord_t'(1);
      end else begin
        pixel_next = Pixel + coord_t'(1);
      end
      // A wrap that keeps the raster running starts a new frame; the wrap
      // that parks the generator does not.
      if (at_end && (state_next != IDLE)) fs_next = 1'b1;
    end

    visible    = (state_next != IDLE);
    de_next    = visible && (pixel_next < H_ACT) && (line_next < V_ACT);
    hsync_next = (visible && (pixel_next >= H_SYNC_START) && (pixel_next <= H_SYNC_END))
                 ? SYNC_POL : ~SYNC_POL;
    vsync_next = (visible && (line_next >= V_SYNC_START) && (line_next <= V_SYNC_END))
                 ? SYNC_POL : ~SYNC_POL;
  end

  // Output and state registers. Reset parks the raster at (0,0) with the
  // syncs at their inactive level.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      Pixel       <= '0;
      Line        <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_next;
      Pixel       <= pixel_next;
      Line        <= line_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      de          <= de_next;
      frame_start <= fs_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Self-checking bench for vga_timing_gen using a shrunken raster
//   (16 x 10 positions, divide-by-4) so whole frames take 640 cycles.
//   A behavioural model steps on every rising edge and pushes the expected
//   output word into a scoreboard queue; the word is popped and compared on
//   the following falling edge. Directed frame measurements add checks on
//   the frame period, sync widths, de area and line-window transitions.
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int DIV      = 4;

  localparam int H_TOTAL = 16;
  localparam int V_TOTAL = 10;
  localparam int HS0 = 10;
  localparam int HS1 = 12;
  localparam int VS0 = 7;
  localparam int VS1 = 8;
  localparam int FRAME = H_TOTAL * V_TOTAL * DIV;

  logic       clk100;
  logic       rst_n;
  logic       run;
  logic       pix_en;
  logic [9:0] Pixel;
  logic [9:0] Line;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic       frame_start;

  int errors = 0;
  int checks = 0;

  logic [31:0] sb_q[$];

  typedef enum {M_IDLE, M_RUN, M_STOP} mstate_t;
  mstate_t m_st;
  int      m_phase;
  int      m_px;
  int      m_ln;
  bit      m_fs;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (DIV),
    .SYNC_POL (1'b0)
  ) dut (
    .clk100      (clk100),
    .rst_n       (rst_n),
    .run         (run),
    .pix_en      (pix_en),
    .Pixel       (Pixel),
    .Line        (Line),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .frame_start (frame_start)
  );

  // 100 MHz clock.
  initial begin
    clk100 = 1'b0;
    forever #5 clk100 = ~clk100;
  end

  function automatic logic [31:0] mk(bit pe, bit fs, bit d, bit hs, bit vs, int ln, int px);
    return {7'd0, pe, fs, d, hs, vs, 10'(ln), 10'(px)};
  endfunction

  function automatic logic [31:0] pack();
    return {7'd0, pix_en, frame_start, de, hsync, vsync, Line, Pixel};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit run_v, input bit rst_v, input int cycles);
    run   = run_v;
    rst_n = rst_v;
    repeat (cycles) @(negedge clk100);
  endtask

  // Reference model: one step per rising edge, written in terms of a
  // per-pixel phase and the run/stop rules of the raster.
  task automatic modelStep();
    bit tick;
    bit wrapped;
    if (!rst_n) begin
      m_st = M_IDLE; m_phase = 0; m_px = 0; m_ln = 0; m_fs = 0;
    end else begin
      m_fs = 0;
      if (m_st == M_IDLE) begin
        if (run) begin
          m_st = M_RUN; m_phase = 0; m_fs = 1;
        end
      end else begin
        tick    = (m_phase == DIV - 1);
        wrapped = 0;
        if (tick) begin
          m_phase = 0;
          m_px++;
          if (m_px == H_TOTAL) begin
            m_px = 0;
            m_ln++;
            if (m_ln == V_TOTAL) begin
              m_ln = 0;
              wrapped = 1;
            end
          end
        end else begin
          m_phase++;
        end
        if (wrapped && !run && m_st == M_STOP) begin
          m_st = M_IDLE;
        end else begin
          if (wrapped) m_fs = 1;
          m_st = run ? M_RUN : M_STOP;
        end
      end
    end
  endtask

  function automatic logic [31:0] expWord();
    bit on;
    on = (m_st != M_IDLE);
    return mk(on && (m_phase == DIV - 1), m_fs,
              on && (m_px < H_ACTIVE) && (m_ln < V_ACTIVE),
              !(on && m_px >= HS0 && m_px <= HS1),
              !(on && m_ln >= VS0 && m_ln <= VS1),
              m_ln, m_px);
  endfunction

  // Scoreboard: push the model's prediction at each rising edge and
  // compare it against the DUT on the following falling edge.
  initial begin
    m_st = M_IDLE; m_phase = 0; m_px = 0; m_ln = 0; m_fs = 0;
    forever begin
      @(posedge clk100);
      modelStep();
      sb_q.push_back(expWord());
      @(negedge clk100);
      checkOutput("raster", pack(), sb_q.pop_front());
    end
  end

  task automatic waitPos(input int px, input int ln, input int budget, input string tag);
    int i;
    i = 0;
    while (!(int'(Pixel) == px && int'(Line) == ln) && i < budget) begin
      @(negedge clk100);
      i++;
    end
    checkOutput(tag, 32'(int'(Pixel) == px && int'(Line) == ln), 32'd1);
  endtask

  // Measures one full frame from a frame_start pulse. When drop_line is
  // non-negative, run is dropped at the start of that line and restored
  // 20 cycles later, which must not disturb the raster.
  task automatic measureFrame(input string tag, input int drop_line);
    int i, de_c, hs_c, vs_c, pe_c, win_c, extra_fs, prev, drop_at;
    i = 0;
    while (!frame_start && i < 2 * FRAME) begin
      @(negedge clk100);
      i++;
    end
    checkOutput($sformatf("%s_fs_seen", tag), 32'(frame_start), 32'd1);
    checkOutput($sformatf("%s_origin", tag), {12'd0, Line, Pixel}, 32'd0);
    de_c = 0; hs_c = 0; vs_c = 0; pe_c = 0; win_c = 0; extra_fs = 0; drop_at = -1;
    prev = int'(Pixel);
    for (int k = 0; k < FRAME; k++) begin
      if (de) de_c++;
      if (!hsync) hs_c++;
      if (!vsync) vs_c++;
      if (pix_en) pe_c++;
      if (frame_start && k != 0) extra_fs++;
      if (drop_line >= 0 && drop_at < 0 && int'(Line) == drop_line && int'(Pixel) == 0) begin
        run = 1'b0;
        drop_at = k;
      end
      if (drop_at >= 0 && k == drop_at + 20) run = 1'b1;
      @(negedge clk100);
      if (prev == H_ACTIVE && int'(Pixel) == H_ACTIVE + 1) win_c++;
      prev = int'(Pixel);
    end
    checkOutput($sformatf("%s_period", tag), 32'(frame_start), 32'd1);
    checkOutput($sformatf("%s_extra_fs", tag), 32'(extra_fs), 32'd0);
    checkOutput($sformatf("%s_de_cycles", tag), 32'(de_c), 32'(H_ACTIVE * V_ACTIVE * DIV));
    checkOutput($sformatf("%s_hsync_cycles", tag), 32'(hs_c), 32'(H_SYNC * DIV * V_TOTAL));
    checkOutput($sformatf("%s_vsync_cycles", tag), 32'(vs_c), 32'(V_SYNC * H_TOTAL * DIV));
    checkOutput($sformatf("%s_pix_en_count", tag), 32'(pe_c), 32'(H_TOTAL * V_TOTAL));
    checkOutput($sformatf("%s_line_window", tag), 32'(win_c), 32'(V_TOTAL));
  endtask

  // Directed sequence.
  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (3) @(negedge clk100);
    checkOutput("reset_state", pack(), mk(0, 0, 0, 1, 1, 0, 0));

    $display("[TB] release reset, idle with run low");
    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("idle_parked", pack(), mk(0, 0, 0, 1, 1, 0, 0));

    $display("[TB] start raster, measure two frames");
    applyStimulus(1'b1, 1'b1, 0);
    measureFrame("frame1", -1);
    measureFrame("frame2", -1);

    $display("[TB] drop run at line 2, expect park at end of frame");
    waitPos(0, 2, FRAME, "reach_line2");
    applyStimulus(1'b0, 1'b1, 0);
    waitPos(H_TOTAL - 1, V_TOTAL - 1, FRAME, "reach_frame_end");
    repeat (DIV + 1) @(negedge clk100);
    for (int k = 0; k < 2 * DIV; k++) begin
      checkOutput("stopped_parked", pack(), mk(0, 0, 0, 1, 1, 0, 0));
      @(negedge clk100);
    end

    $display("[TB] restart, drop and re-assert run at line 3");
    applyStimulus(1'b1, 1'b1, 0);
    measureFrame("glitch", 3);
    measureFrame("after_glitch", -1);

    $display("[TB] async reset inside the sync windows");
    waitPos(HS0 + 1, VS0 + 1, FRAME, "reach_reset_point");
    #1 rst_n = 1'b0;
    #1 checkOutput("async_reset", pack(), mk(0, 0, 0, 1, 1, 0, 0));
    repeat (3) @(negedge clk100);
    applyStimulus(1'b1, 1'b1, 0);
    measureFrame("after_reset", -1);

    repeat (4) @(negedge clk100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
